// File: rtl/div_pkg.sv
// div_pkg: shared types and defaults for the iterative restoring divider.
//   e_div_state         - FSM state encoding (IDLE, DIV1)
//   DefaultWidth        - default operand/result width
//   DefaultBitsPerCycle - default quotient bits retired per iteration
package div_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DIV1 = 1'b1
  } e_div_state;

  localparam int unsigned DefaultWidth        = 32;
  localparam int unsigned DefaultBitsPerCycle = 2;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Ports:
//   rem_in       - partial remainder entering this step (always < divisor, or any value if divisor=0)
//   divisor      - unsigned divisor
//   dividend_bit - next dividend bit, shifted in at the LSB
//   rem_out      - partial remainder after the step
//   quotient_bit - 1 when the trial subtraction did not borrow
module div_step
  import div_pkg::*;
#(
  parameter int unsigned width = DefaultWidth
) (
  input  logic [width-1:0] rem_in,
  input  logic [width-1:0] divisor,
  input  logic             dividend_bit,
  output logic [width-1:0] rem_out,
  output logic             quotient_bit
);

  logic [width:0]   shifted;
  logic [width+1:0] trial;
  logic             unused_bits;

  // The shifted remainder is width+1 bits wide; the extra top bit of trial is the
  // borrow, so the comparison never wraps.
  always_comb begin
    shifted      = {rem_in, dividend_bit};
    trial        = {1'b0, shifted} - {2'b00, divisor};
    quotient_bit = ~trial[width+1];
    rem_out      = quotient_bit ? trial[width-1:0] : shifted[width-1:0];
  end

  // When a difference is kept it is below the divisor, so its bit [width] is
  // zero. When divisor=0 the remainder's shifted-out MSB is dropped on purpose
  // so that, after width steps, the remainder equals the dividend.
  assign unused_bits = ^{trial[width], shifted[width]};

endmodule

// File: rtl/div_pipeline_32bit.sv
// div_pipeline_32bit: iterative unsigned divider, bits_per_cycle restoring steps
// per clock, chained MSB first.
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset
//   req       - start request, sampled only in IDLE
//   a, b      - dividend and divisor, captured with req
//   quotient  - registered quotient, valid from the ack edge until the next completion
//   remainder - registered remainder, valid with quotient
//   ack       - one-cycle completion pulse
// Configuration macro:
//   DIV_ZERO_FAST_EN - when defined, b=0 skips the iteration sequence and acks one
//                      cycle after acceptance; otherwise b=0 takes the full latency.
// Latency: req sampled at edge E0 -> ack at E0 + width/bits_per_cycle.
module div_pipeline_32bit
  import div_pkg::*;
#(
  parameter int unsigned width          = DefaultWidth,
  parameter int unsigned bits_per_cycle = DefaultBitsPerCycle
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder,
  output logic             ack
);

  localparam int unsigned Iters = width / bits_per_cycle;
  localparam int unsigned CntW  = $clog2(width) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Iters - 1);

  e_div_state       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Dividend shifts out MSB first while quotient bits shift in at the LSB; after
  // the last iteration this register holds the full quotient.
  logic [width-1:0] dvd_q, dvd_d;
  logic [width-1:0] div_q, div_d;
  logic [width-1:0] prem_q, prem_d;
  logic [width-1:0] quo_q, quo_d;
  logic [width-1:0] rem_q, rem_d;
  logic             ack_q, ack_d;

  logic [width-1:0]          chain_rem [bits_per_cycle+1];
  logic [bits_per_cycle-1:0] q_bits;
  logic [width-1:0]          dvd_next;

  assign chain_rem[0] = prem_q;

  // Step i consumes dividend bit width-1-i and produces the i-th most significant
  // of this cycle's quotient bits.
  for (genvar i = 0; i < bits_per_cycle; i++) begin : g_step
    div_step #(
      .width(width)
    ) u_step (
      .rem_in      (chain_rem[i]),
      .divisor     (div_q),
      .dividend_bit(dvd_q[width-1-i]),
      .rem_out     (chain_rem[i+1]),
      .quotient_bit(q_bits[bits_per_cycle-1-i])
    );
  end

  assign dvd_next = (dvd_q << bits_per_cycle) | width'(q_bits);

`ifdef DIV_ZERO_FAST_EN
  // Set when b=0 was accepted; the result is published one cycle later.
  logic zero_pend_q, zero_pend_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    ack_d   = 1'b0;
`ifdef DIV_ZERO_FAST_EN
    zero_pend_d = zero_pend_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef DIV_ZERO_FAST_EN
        if (zero_pend_q) begin
          zero_pend_d = 1'b0;
          ack_d       = 1'b1;
          quo_d       = '1;
          rem_d       = dvd_q;
        end else if (req) begin
          dvd_d  = a;
          div_d  = b;
          prem_d = '0;
          cnt_d  = '0;
          if (b == '0) begin
            zero_pend_d = 1'b1;
          end else begin
            state_d = DIV1;
          end
        end
`else
        if (req) begin
          dvd_d   = a;
          div_d   = b;
          prem_d  = '0;
          cnt_d   = '0;
          state_d = DIV1;
        end
`endif
      end
      DIV1: begin
        dvd_d  = dvd_next;
        prem_d = chain_rem[bits_per_cycle];
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = IDLE;
          ack_d   = 1'b1;
          quo_d   = dvd_next;
          rem_d   = chain_rem[bits_per_cycle];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ack_q   <= ack_d;
    end
  end

`ifdef DIV_ZERO_FAST_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_pend_q <= 1'b0;
    end else begin
      zero_pend_q <= zero_pend_d;
    end
  end
`endif

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign ack       = ack_q;

endmodule

// File: tb/tb_div_pipeline_32bit.sv
// tb_div_pipeline_32bit: directed and random checks of div_pipeline_32bit against
// a plain-arithmetic reference (a/b, a%b, with b=0 giving all ones and a).
module tb_div_pipeline_32bit;

  localparam int Iters = 16;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        ack;

  int total = 0;
  int bad   = 0;

  div_pipeline_32bit #(
    .width         (32),
    .bits_per_cycle(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .a        (a),
    .b        (b),
    .quotient (quotient),
    .remainder(remainder),
    .ack      (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] ref_q(input logic [31:0] x, input logic [31:0] y);
    return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
  endfunction

  function automatic logic [31:0] ref_r(input logic [31:0] x, input logic [31:0] y);
    return (y == 32'd0) ? x : x % y;
  endfunction

  function automatic int ref_lat(input logic [31:0] y);
`ifdef DIV_ZERO_FAST_EN
    return (y == 32'd0) ? 1 : Iters;
`else
    return Iters;
`endif
  endfunction

  // One request; checks latency, results, single-cycle ack and result hold.
  task automatic run_div(input string tag, input logic [31:0] x, input logic [31:0] y);
    int lat;
    bit got;
    logic [31:0] eq;
    logic [31:0] er;
    eq  = ref_q(x, y);
    er  = ref_r(x, y);
    got = 1'b0;
    lat = 0;
    @(negedge clk);
    req = 1'b1;
    a   = x;
    b   = y;
    @(posedge clk);  // E0
    #1;
    req = 1'b0;
    a   = ~x;        // captured operands must not follow the inputs
    b   = ~y;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        got = 1'b1;
        lat = k;
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(ref_lat(y)));
    check({tag, ".q"}, quotient, eq);
    check({tag, ".r"}, remainder, er);
    @(posedge clk);
    #1;
    check({tag, ".ack_once"}, {31'd0, ack}, 32'd0);
    check({tag, ".q_hold"}, quotient, eq);
    check({tag, ".r_hold"}, remainder, er);
  endtask

  initial begin
    int ack_cnt;
    int ack_at [2];
    logic [31:0] q_at [2];
    logic [31:0] r_at [2];
    bit seen;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b0;
    req = 1'b0;
    a   = '0;
    b   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ack", {31'd0, ack}, 32'd0);
    check("rst.q", quotient, 32'd0);
    check("rst.r", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div("d100_7", 32'd100, 32'd7);
    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1);
    run_div("d3_10", 32'd3, 32'd10);
    run_div("d5_0", 32'd5, 32'd0);
    run_div("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_div("d8000_3", 32'h8000_0000, 32'd3);

    // Back-to-back with req held high; operands change while busy.
    ack_cnt = 0;
    @(negedge clk);
    req = 1'b1;
    a   = 32'd50;
    b   = 32'd5;
    @(posedge clk);  // E0
    #1;
    a = 32'd9;
    b = 32'd4;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 17) req = 1'b0;
      if (ack) begin
        if (ack_cnt < 2) begin
          ack_at[ack_cnt] = k;
          q_at[ack_cnt]   = quotient;
          r_at[ack_cnt]   = remainder;
        end
        ack_cnt++;
      end
    end
    check("b2b.acks", 32'(ack_cnt), 32'd2);
    if (ack_cnt >= 2) begin
      check("b2b.ack0_at", 32'(ack_at[0]), 32'd16);
      check("b2b.ack1_at", 32'(ack_at[1]), 32'd33);
      check("b2b.q0", q_at[0], 32'd10);
      check("b2b.r0", r_at[0], 32'd0);
      check("b2b.q1", q_at[1], 32'd2);
      check("b2b.r1", r_at[1], 32'd1);
    end

    // Reset mid-operation aborts; results clear immediately.
    run_div("pre_rst", 32'd1000, 32'd3);
    @(negedge clk);
    req = 1'b1;
    a   = 32'd1000;
    b   = 32'd3;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort.ack", {31'd0, ack}, 32'd0);
    check("abort.q", quotient, 32'd0);
    check("abort.r", remainder, 32'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (ack) seen = 1'b1;
    end
    check("abort.no_ack", {31'd0, seen}, 32'd0);
    run_div("d20_6", 32'd20, 32'd6);

    // Random operands, biased toward interesting divisor sizes.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 255));
        2: rb = ra >> $urandom_range(0, 31);
        default: rb = (i % 8 == 7) ? 32'd0 : ($urandom & 32'h0000_FFFF);
      endcase
      run_div($sformatf("rnd%0d", i), ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_pipeline_32bit.md
DIV_PIPELINE_32BIT -- requirements
Module: div_pipeline_32bit

Interface
REQ-001 Parameter width, default 32: operand and result width in bits.
REQ-002 Parameter bits_per_cycle, default 2: quotient bits retired per iteration cycle; width SHALL be an integer multiple of bits_per_cycle.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  async active-low reset.
REQ-005 req  input  1  start request; sampled only in IDLE.
REQ-006 a  input  width  unsigned dividend; sampled with req.
REQ-007 b  input  width  unsigned divisor; sampled with req.
REQ-008 quotient  output  width  registered quotient.
REQ-009 remainder  output  width  registered remainder.
REQ-010 ack  output  1  registered completion pulse.
REQ-011 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-012 The FSM SHALL have states IDLE and DIV1.
- IDLE -> DIV1 on a rising edge with req=1; a and b are captured into internal registers, the partial remainder is cleared and the iteration counter is set to 0.
- DIV1 -> IDLE after the final iteration.
REQ-013 Each DIV1 cycle SHALL perform bits_per_cycle chained restoring-division steps, MSB first.
- Each step: shift in the next dividend bit, trial-subtract the divisor, keep the difference if it is non-negative, and write the quotient bit.
REQ-014 Latency: with req sampled at edge E0, ack SHALL be high for exactly one cycle, starting at edge E0 + width/bits_per_cycle (E0+16 at the defaults).
REQ-015 quotient and remainder SHALL become valid at the same edge ack rises, and SHALL hold until the next completion or reset.
REQ-016 req SHALL be ignored while in DIV1; the captured operands SHALL NOT change mid-operation.
REQ-017 Back-to-back: req=1 during the ack cycle SHALL be accepted at the next edge, because the FSM is already in IDLE.
REQ-018 Divide by zero (b=0) SHALL yield quotient = all ones and remainder = a, without asserting any error.
REQ-019 When a < b, the block SHALL yield quotient = 0 and remainder = a.
REQ-020 All arithmetic SHALL be unsigned at width bits. The trial subtraction SHALL use width+1 bits, so that no borrow is lost.
REQ-021 ack SHALL never be asserted for two consecutive cycles from a single request.

Reset
REQ-022 While rst=0, the block SHALL set state=IDLE, ack=0, quotient=0, remainder=0, iteration counter=0 and partial remainder=0.
REQ-023 Reset asserted mid-operation SHALL abort the division; no ack SHALL follow for the aborted request.
REQ-024 The first req after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 Macro DIV_ZERO_FAST_EN controls divide-by-zero latency.
- Defined: b=0 sampled in IDLE SHALL skip DIV1; ack SHALL pulse at edge E0+1 with quotient all ones and remainder = a.
- Undefined: b=0 SHALL run the full iteration sequence, with the same results and latency as REQ-014.

Structure
REQ-026 Shared package div_pkg SHALL hold:
- the state enum e_div_state {IDLE, DIV1};
- the default width and bits_per_cycle constants.
REQ-027 Sub-module div_step SHALL implement one combinational restoring step.
- Inputs: partial remainder, divisor, dividend bit.
- Outputs: next partial remainder, quotient bit.
- The top level SHALL instantiate bits_per_cycle copies in a chain.
REQ-028 The iteration counter width SHALL be $clog2(width)+1.

Verification
REQ-029 a=100, b=7, req at E0 -> ack at E0+16 with quotient=14, remainder=2.
REQ-030 a=0xFFFFFFFF, b=1 -> quotient=0xFFFFFFFF, remainder=0, ack at E0+16.
REQ-031 a=3, b=10 -> quotient=0, remainder=3.
REQ-032 a=5, b=0 -> quotient=0xFFFFFFFF, remainder=5.
- Ack at E0+1 with DIV_ZERO_FAST_EN defined.
- Ack at E0+16 without it.
REQ-033 req held high continuously with a=50, b=5 and then a=9, b=4:
- one ack per accepted request, every 17 cycles;
- results are q=10 r=0, then q=2 r=1.
REQ-034 rst pulled low 8 cycles after req -> ack=0, quotient=0 and remainder=0 immediately; no ack follows; the next req with a=20, b=6 -> q=3, r=2.
